// File: rtl/nn_io_pkg.sv
// rtl/nn_io_pkg.sv - shared sample/pair types for the NN front-end I/O path
package nn_io_pkg;

  localparam int SAMPLE_W = 32;

  // Pad sample for a flushed odd sample; the normalizer maps it to 0.
  localparam logic [SAMPLE_W-1:0] PAD_VALUE = 32'hFFFC0001;

  typedef enum logic {
    S_LO,
    S_HI
  } pair_state_t;

  typedef logic [2*SAMPLE_W-1:0] pair_word_t;

endpackage

// File: rtl/sample_pair_tx_if.sv
// rtl/sample_pair_tx_if.sv - sample stream handshake between source and packer
interface sample_pair_tx_if;
  import nn_io_pkg::*;

  logic [SAMPLE_W-1:0] s_data;
  logic                s_valid;
  logic                s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous sample FIFO with count-based full/empty
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             full,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  // A full FIFO refuses a push even if a pop frees a slot in the same cycle.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_valid && !full;
  assign pop     = rd && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sample_pair_tx.sv
// rtl/sample_pair_tx.sv - packs consecutive samples into 64-bit input_V pulses
module sample_pair_tx
  import nn_io_pkg::*;
#(
  parameter int SAMPLE_W   = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int II         = 2
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  sample_pair_tx_if.slave        s,
  input  logic                   enable,
  input  logic                   flush,
  output pair_word_t             input_V,
  output logic                   input_V_ap_vld,
  output logic                   busy,
  output logic [15:0]            pairs_sent
);

  localparam int GAP_W = (II > 1) ? $clog2(II) : 1;

  pair_state_t         state;
  pair_state_t         state_next;
  logic [SAMPLE_W-1:0] lo_reg;
  logic [SAMPLE_W-1:0] head;
  logic [GAP_W-1:0]    gap_cnt;
  logic                full;
  logic                empty;
  logic                pop;
  logic                emit;
  logic                use_pad;

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .wr_data  (s.s_data),
    .wr_valid (s.s_valid),
    .full     (full),
    .rd       (pop),
    .rd_data  (head),
    .empty    (empty)
  );

  assign s.s_ready = !full;
  assign busy      = (state == S_HI) || !empty || (gap_cnt != '0);

  // Pairing decisions: a real sample beats flush, and the gap only blocks emission.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    emit       = 1'b0;
    use_pad    = 1'b0;
    case (state)
      S_LO: begin
        if (enable && !empty) begin
          pop        = 1'b1;
          state_next = S_HI;
        end
      end
      S_HI: begin
        if (enable && (gap_cnt == '0)) begin
          if (!empty) begin
            pop        = 1'b1;
            emit       = 1'b1;
            state_next = S_LO;
          end else if (flush) begin
            emit       = 1'b1;
            use_pad    = 1'b1;
            state_next = S_LO;
          end
        end
      end
      default: state_next = S_LO;
    endcase
  end

  // State, held first sample, spacing counter and registered outputs.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state          <= S_LO;
      lo_reg         <= '0;
      gap_cnt        <= '0;
      input_V        <= '0;
      input_V_ap_vld <= 1'b0;
      pairs_sent     <= '0;
    end else begin
      state          <= state_next;
      input_V_ap_vld <= emit;
      if (state == S_LO && pop) lo_reg <= head;
      if (emit) begin
        input_V    <= {(use_pad ? PAD_VALUE : head), lo_reg};
        gap_cnt    <= GAP_W'(II - 1);
        pairs_sent <= pairs_sent + 16'd1;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample_pair_tx.sv
// tb/tb_sample_pair_tx.sv - directed self-checking bench for sample_pair_tx
module tb_sample_pair_tx;
  import nn_io_pkg::*;

  localparam int II = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  pair_word_t  input_V;
  logic        vld;
  logic        busy;
  logic [15:0] pairs_sent;

  sample_pair_tx_if sif ();

  sample_pair_tx #(
    .SAMPLE_W   (32),
    .FIFO_DEPTH (4),
    .II         (II)
  ) dut (
    .ap_clk         (clk),
    .ap_rst_n       (rst_n),
    .s              (sif.slave),
    .enable         (enable),
    .flush          (flush),
    .input_V        (input_V),
    .input_V_ap_vld (vld),
    .busy           (busy),
    .pairs_sent     (pairs_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pair_word_t pq[$];
  int         pc[$];
  always @(negedge clk) begin
    if (vld) begin
      pq.push_back(input_V);
      pc.push_back(cyc);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pulse(input int i);
    return (pq.size() > i) ? pq[i] : 64'hx;
  endfunction

  function automatic int pulse_cyc(input int i);
    return (pc.size() > i) ? pc[i] : -1000;
  endfunction

  task automatic clear_log();
    pq.delete();
    pc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one sample until accepted; leaves s_valid high for back-to-back use.
  task automatic send(input logic [31:0] d, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    sif.s_data  = d;
    sif.s_valid = 1'b1;
    while (acc_cyc < 0 && n < 50) begin
      @(negedge clk);
      if (sif.s_ready) acc_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    check("send_accept", 64'(acc_cyc >= 0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, a, acc, n;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;

    // Reset state
    @(negedge clk);
    check("rst_input_V", input_V, 64'd0);
    check("rst_vld", vld, 0);
    check("rst_pairs", pairs_sent, 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready", sif.s_ready, 1);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    enable = 1'b1;
    idle(2);

    // Pair latency
    clear_log();
    send(32'h00000005, t0);
    send(32'hFFFFFFFB, t1);
    sif.s_valid = 1'b0;
    idle(10);
    check("lat_back_to_back", t1, t0 + 1);
    check("lat_count", pq.size(), 1);
    check("lat_data", pulse(0), 64'hFFFFFFFB_00000005);
    check("lat_cycle", pulse_cyc(0), t0 + 3);
    check("lat_pairs", pairs_sent, 1);

    // Burst of 8 with II spacing
    clear_log();
    for (int i = 1; i <= 8; i++) send(32'(i), a);
    sif.s_valid = 1'b0;
    idle(30);
    check("burst_count", pq.size(), 4);
    for (int k = 0; k < 4; k++)
      check("burst_data", pulse(k), {32'(2*k+2), 32'(2*k+1)});
    for (int k = 1; k < 4; k++)
      check("burst_gap", 64'((pulse_cyc(k) - pulse_cyc(k-1)) >= II), 64'd1);
    check("burst_pairs", pairs_sent, 5);
    check("burst_idle_busy", busy, 0);

    // Flush pads an odd sample
    clear_log();
    send(32'h00000100, a);
    sif.s_valid = 1'b0;
    idle(6);
    check("flush_hold_busy", busy, 1);
    flush = 1'b1; idle(1); flush = 1'b0;
    idle(6);
    check("flush_count", pq.size(), 1);
    check("flush_data", pulse(0), 64'hFFFC0001_00000100);
    clear_log();
    flush = 1'b1; idle(1); flush = 1'b0;
    idle(6);
    check("flush_empty_count", pq.size(), 0);
    check("flush_pairs", pairs_sent, 6);

    // Enable low: FIFO fills, nothing emitted
    clear_log();
    enable = 1'b0;
    acc = 0;
    sif.s_valid = 1'b1;
    sif.s_data  = 32'h11;
    repeat (10) begin
      @(negedge clk);
      if (sif.s_ready) acc++;
      @(posedge clk); #1;
      sif.s_data = 32'(32'h11 + acc);
    end
    check("en_accepted", acc, 4);
    check("en_s_ready", sif.s_ready, 0);
    check("en_no_pulse", pq.size(), 0);
    check("en_busy", busy, 1);
    enable = 1'b1;
    n = 0;
    while (acc < 6 && n < 40) begin
      @(negedge clk);
      if (sif.s_ready) acc++;
      @(posedge clk); #1;
      sif.s_data = 32'(32'h11 + acc);
      n++;
    end
    sif.s_valid = 1'b0;
    idle(20);
    check("en_all_accepted", acc, 6);
    check("en_count", pq.size(), 3);
    check("en_data0", pulse(0), {32'h12, 32'h11});
    check("en_data1", pulse(1), {32'h14, 32'h13});
    check("en_data2", pulse(2), {32'h16, 32'h15});
    check("en_pairs", pairs_sent, 9);

    // Reset while holding a first sample
    clear_log();
    send(32'h7, a);
    sif.s_valid = 1'b0;
    idle(3);
    check("mid_busy_hi", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", vld, 0);
    check("mid_rst_pairs", pairs_sent, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    send(32'h1, a);
    send(32'h2, a);
    sif.s_valid = 1'b0;
    idle(8);
    check("mid_count", pq.size(), 1);
    check("mid_data", pulse(0), 64'h00000002_00000001);
    check("mid_pairs", pairs_sent, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_pair_tx.md
# sample_pair_tx

Transmit-side packer for the NN front end. It accepts a stream of signed 32-bit ADC samples, buffers them and pairs consecutive samples into one 64-bit word. It drives that word to the normalizer's `input_V` / `input_V_ap_vld` port as a single-cycle valid pulse, with a minimum spacing between pulses. It sits between the sample source and the normalize/NN pipeline.

## Interface
Parameters:
- `SAMPLE_W`, 32: width of one sample (fixed by the 64-bit `input_V` word).
- `FIFO_DEPTH`, 4: sample buffer depth (power of two, ≥2).
- `II`, 2: minimum cycles between `input_V_ap_vld` pulses (≥1).

Ports:
- `ap_clk`  in  1: clock. One clock domain.
- `ap_rst_n`  in  1: reset, asynchronous assert, active-low.
- `s_data`  in  32: signed sample.
- `s_valid`  in  1: `s_data` valid.
- `s_ready`  out  1: buffer can accept. A transfer occurs when `s_valid && s_ready`.
- `enable`  in  1: permits popping and emission.
- `flush`  in  1: pads a held odd sample.
- `input_V`  out  64: {second sample, first sample}.
- `input_V_ap_vld`  out  1: one-cycle pulse, `input_V` valid.
- `busy`  out  1: work pending.
- `pairs_sent`  out  16: count of emitted words; wraps modulo 2^16.

## Operation
- Input FIFO of `FIFO_DEPTH` samples.
  - `s_ready = !full`, combinational from the occupancy count.
  - A push is refused when full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle are allowed when not full.
- Pairing FSM:
  - `S_LO`: if `enable` and FIFO not empty, pop the head into `lo_reg` and go to `S_HI`.
  - `S_HI`: emit when `enable` and `gap_cnt == 0` and one of these holds:
    - FIFO not empty: pop the head, and emit `input_V = {head, lo_reg}`.
    - FIFO empty and `flush` high: emit `input_V = {PAD_VALUE, lo_reg}` with no pop.
  - On emission:
    - pulse `ap_vld` for one cycle;
    - load `gap_cnt = II-1`;
    - increment `pairs_sent`;
    - return to `S_LO`.
  - A real sample always wins over `flush`. `flush` in `S_LO` is ignored.
- `PAD_VALUE = 32'hFFFC0001` (−262143). The normalizer maps this value to 0.
- `gap_cnt` decrements to 0 every cycle regardless of `enable`. Popping into `lo_reg` may proceed while `gap_cnt != 0`.
- `enable` low: no pops and no emission. The FIFO still fills, and `lo_reg` and the state hold.
- `input_V` holds its last value between pulses.
- `busy = (state == S_HI) || !empty || (gap_cnt != 0)`.
- Sample order is strictly preserved: the first sample goes in bits [31:0] and the second in [63:32].

## Timing
- Reset values (asynchronous, while `ap_rst_n` = 0):
  - `input_V` = 0, `input_V_ap_vld` = 0, `pairs_sent` = 0, `busy` = 0;
  - state `S_LO`, FIFO empty, `gap_cnt` = 0;
  - so `s_ready` = 1.
- FIFO latency: a sample accepted at cycle t is at the head, and poppable, at t+1.
- Pair latency: with samples accepted at cycles t and t+1 from an empty, idle block, `input_V_ap_vld` is high during cycle t+3 only.
- Throughput: at most one word per 2 cycles (one pop per cycle), further limited to one per `II` cycles. Rising `ap_vld` edges are always ≥ max(2, `II`) cycles apart.
- Reset mid-operation:
  - `ap_vld` drops immediately;
  - the held `lo_reg` and all FIFO contents are discarded, with no partial emission;
  - the first sample after reset release starts a fresh pair.
- Outputs are all registered, except `s_ready` and `busy`, which are decoded combinationally from registers.

## Structure
- Shared package `nn_io_pkg`:
  - `SAMPLE_W`;
  - `PAD_VALUE`;
  - the pair state enum (`S_LO`, `S_HI`);
  - the `pair_word_t` 64-bit typedef.
- Sub-module `sample_fifo`:
  - parameterized synchronous FIFO, width `SAMPLE_W`, depth `FIFO_DEPTH`, asynchronous active-low reset;
  - `full` and `empty` flags from a `$clog2(FIFO_DEPTH)+1`-bit count.
- The top level contains the FSM, `lo_reg`, `gap_cnt`, the output registers and `pairs_sent`.

## Test plan
- Reset, then release → all outputs 0, `s_ready` = 1, `busy` = 0.
- `II` = 2. Accept `32'h00000005` at cycle 0 and `32'hFFFFFFFB` at cycle 1 → `ap_vld` high only at cycle 3, `input_V = 64'hFFFFFFFB_00000005`, `pairs_sent` = 1.
- `II` = 4. Burst of 8 samples 1..8 with `s_valid` held high → `s_ready` drops while the FIFO is full, and 4 pulses arrive ≥4 cycles apart: {2,1}, {4,3}, {6,5}, {8,7}.
- Single sample `32'h00000100`, then `flush` for one cycle → one pulse with `input_V = 64'hFFFC0001_00000100`. A further `flush` with nothing held → no pulse.
- `enable` = 0 while offering 6 samples → exactly 4 accepted, `s_ready` = 0, no pulse. Raise `enable` → 2 pulses, then the remaining 2 samples accepted.
- Assert `ap_rst_n` low in `S_HI` holding `32'h7` → `ap_vld` = 0 and `pairs_sent` = 0 immediately. After release, samples `32'h1`, `32'h2` → `input_V = 64'h00000002_00000001`.
